// File: rtl/i3c_axi_sub_mem.sv
// rtl/i3c_axi_sub_mem.sv - I3C/AXI subordinate memory with wait states and read latency pipeline
// Register-based memory so reset clears every word; reads are sampled at acceptance.
module i3c_axi_sub_mem #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int UW      = 32,
  parameter int IW      = 1,
  parameter int DEPTH   = 16,
  parameter int C_LAT   = 1,
  parameter int WAIT_ST = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dv,
  input  logic [AW-1:0] addr,
  input  logic          write,
  input  logic [UW-1:0] user,
  input  logic [IW-1:0] id,
  input  logic          last,
  input  logic [DW-1:0] wdata,
  input  logic [DW/8-1:0] wstrb,
  input  logic [2:0]    size,
  output logic          hld,
  output logic          rd_err,
  output logic          wr_err,
  output logic [DW-1:0] rdata
);
  localparam int BC  = DW / 8;
  localparam int BW  = $clog2(BC);
  localparam int IXW = $clog2(DEPTH);
  localparam logic [3:0]       WST4     = 4'(WAIT_ST);
  localparam logic [AW-BW-1:0] HI_DEPTH = (AW-BW)'(DEPTH);
  localparam logic [2:0]       SZ_MAX   = 3'(BW);

  logic [3:0]     cnt_q, cnt_d;
  logic [DW-1:0]  mem_q [DEPTH];
  logic [DW-1:0]  mem_d [DEPTH];
  logic [IXW-1:0] idx;
  logic [AW-BW-1:0] word_hi;
  logic           err, acc, rd_acc;
  logic [DW-1:0]  rd_word;
  logic           unused_ok;

  assign unused_ok = ^{user, id, last, addr[BW-1:0]};
  assign idx      = addr[BW +: IXW];
  assign word_hi  = addr[AW-1:BW];
  assign err      = (word_hi >= HI_DEPTH) || (size > SZ_MAX);
  assign hld      = (cnt_q != 4'd0);
  assign acc      = dv && !hld;
  assign rd_acc   = acc && !write;
  assign wr_err   = acc && write && err;
  assign rd_word  = err ? '0 : mem_q[idx];

  // Counter only moves while a request is presented; acceptance reloads it.
  always_comb begin
    cnt_d = cnt_q;
    if (dv) begin
      if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      else               cnt_d = WST4;
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (acc && write && !err) begin
      for (int b = 0; b < BC; b++) begin
        if (wstrb[b]) mem_d[idx][8*b +: 8] = wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= WST4;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

  if (C_LAT == 0) begin : g_comb
    assign rdata  = rd_acc ? rd_word : '0;
    assign rd_err = rd_acc && err;
  end else begin : g_pipe
    logic [C_LAT-1:0] vld_q, vld_d, perr_q, perr_d;
    logic [DW-1:0]    pdat_q [C_LAT];
    logic [DW-1:0]    pdat_d [C_LAT];

    always_comb begin
      vld_d[0]  = rd_acc;
      perr_d[0] = rd_acc && err;
      pdat_d[0] = rd_acc ? rd_word : '0;
      for (int i = 1; i < C_LAT; i++) begin
        vld_d[i]  = vld_q[i-1];
        perr_d[i] = perr_q[i-1];
        pdat_d[i] = pdat_q[i-1];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q  <= '0;
        perr_q <= '0;
        for (int i = 0; i < C_LAT; i++) pdat_q[i] <= '0;
      end else begin
        vld_q  <= vld_d;
        perr_q <= perr_d;
        pdat_q <= pdat_d;
      end
    end

    assign rdata  = vld_q[C_LAT-1] ? pdat_q[C_LAT-1] : '0;
    assign rd_err = vld_q[C_LAT-1] && perr_q[C_LAT-1];
  end

endmodule

// File: tb/tb_i3c_axi_sub_mem.sv
// tb/tb_i3c_axi_sub_mem.sv - self-checking bench, four configurations against a byte-level model
// Each configuration has its own model; all share one stimulus bus.
module tb_i3c_axi_sub_mem;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dv = 1'b0, write = 1'b0, last = 1'b0;
  logic [31:0] addr = '0, wdata = '0, user = '0;
  logic [0:0]  id = '0;
  logic [3:0]  wstrb = '0;
  logic [2:0]  size = '0;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_cfg
    localparam int CL = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 2 : 0;
    localparam int WS = (g == 3) ? 3 : 0;
    logic        hld, rd_err, wr_err;
    logic [31:0] rdata;

    i3c_axi_sub_mem #(.C_LAT(CL), .WAIT_ST(WS)) u_dut (
      .clk(clk), .rst_n(rst_n), .dv(dv), .addr(addr), .write(write),
      .user(user), .id(id), .last(last), .wdata(wdata), .wstrb(wstrb),
      .size(size), .hld(hld), .rd_err(rd_err), .wr_err(wr_err), .rdata(rdata)
    );

    logic [7:0]  mbytes [64];
    int          mcnt;
    int          mcyc = 0;
    int          q_due [$];
    logic        q_err [$];
    logic [31:0] q_dat [$];

    always @(negedge clk) begin
      logic        e_hld, e_wr, e_rerr, acc, err;
      logic [31:0] e_rd, word;
      int          w;
      if (!rst_n) begin
        for (int i = 0; i < 64; i++) mbytes[i] = 8'h00;
        mcnt = WS;
        q_due.delete(); q_err.delete(); q_dat.delete();
      end
      e_hld  = (mcnt != 0);
      acc    = dv && !e_hld;
      err    = (addr >= 32'd64) || (size > 3'd2);
      w      = int'(addr[5:2]);
      word   = {mbytes[4*w+3], mbytes[4*w+2], mbytes[4*w+1], mbytes[4*w]};
      e_wr   = acc && write && err;
      e_rd   = '0;
      e_rerr = 1'b0;
      if (rst_n) begin
        if (CL == 0) begin
          if (acc && !write) begin
            e_rerr = err;
            e_rd   = err ? 32'h0 : word;
          end
        end else if (q_due.size() > 0 && q_due[0] == mcyc) begin
          e_rerr = q_err[0];
          e_rd   = q_dat[0];
          void'(q_due.pop_front()); void'(q_err.pop_front()); void'(q_dat.pop_front());
        end
      end
      chk($sformatf("cfg%0d hld cyc%0d", g, mcyc), {31'b0, hld}, {31'b0, e_hld});
      chk($sformatf("cfg%0d wr_err cyc%0d", g, mcyc), {31'b0, wr_err}, {31'b0, e_wr});
      chk($sformatf("cfg%0d rd_err cyc%0d", g, mcyc), {31'b0, rd_err}, {31'b0, e_rerr});
      chk($sformatf("cfg%0d rdata cyc%0d", g, mcyc), rdata, e_rd);
      if (rst_n) begin
        if (acc && write && !err) begin
          for (int b = 0; b < 4; b++) if (wstrb[b]) mbytes[4*w+b] = wdata[8*b +: 8];
        end
        if (acc && !write && CL > 0) begin
          q_due.push_back(mcyc + CL);
          q_err.push_back(err);
          q_dat.push_back(err ? 32'h0 : word);
        end
        if (dv) mcnt = e_hld ? mcnt - 1 : WS;
      end
      mcyc++;
    end
  end

  task automatic cyc(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic [2:0] sz);
    @(posedge clk); #1;
    dv = v; write = w; addr = a; wdata = d; wstrb = s; size = sz;
    user = $urandom; id = 1'($urandom); last = 1'($urandom);
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'd2);
  endtask

  logic [9:0] hv_dv  = 10'b1111100111;
  logic [9:0] hv_hld = 10'b1110111110;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst cfg0 rdata", g_cfg[0].rdata, 32'h0);
    chk("rst cfg0 hld", {31'b0, g_cfg[0].hld}, 32'h0);
    chk("rst cfg3 hld", {31'b0, g_cfg[3].hld}, 32'h1);
    @(posedge clk); #1 rst_n = 1'b1;

    cyc(1'b1, 1'b1, 32'h8, 32'hDEADBEEF, 4'hF, 3'd2);
    cyc(1'b1, 1'b0, 32'h8, 32'h0, 4'h0, 3'd2);
    chk("deadbeef not yet", g_cfg[0].rdata, 32'h0);
    idle();
    chk("deadbeef rdata", g_cfg[0].rdata, 32'hDEADBEEF);
    chk("deadbeef rd_err", {31'b0, g_cfg[0].rd_err}, 32'h0);

    cyc(1'b1, 1'b1, 32'h4, 32'h11223344, 4'hF, 3'd2);
    cyc(1'b1, 1'b1, 32'h4, 32'hAABBCCDD, 4'h5, 3'd2);
    cyc(1'b1, 1'b0, 32'h4, 32'h0, 4'h0, 3'd2);
    idle();
    chk("strobe merge", g_cfg[0].rdata, 32'h11BB33DD);

    cyc(1'b1, 1'b1, 32'h40, 32'h12345678, 4'hF, 3'd2);
    chk("oor wr_err", {31'b0, g_cfg[0].wr_err}, 32'h1);
    cyc(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 3'd2);
    idle();
    chk("oor rd_err", {31'b0, g_cfg[0].rd_err}, 32'h1);
    chk("oor rdata", g_cfg[0].rdata, 32'h0);
    cyc(1'b1, 1'b0, 32'h8, 32'h0, 4'h0, 3'd3);
    idle();
    chk("size3 rd_err", {31'b0, g_cfg[0].rd_err}, 32'h1);
    cyc(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 3'd2);
    idle();
    chk("word0 untouched", g_cfg[0].rdata, 32'h0);

    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 32'(4*i), 32'(i+1), 4'hF, 3'd2);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 32'(4*i), 32'h0, 4'h0, 3'd2);
    chk("lat3 beat1", g_cfg[1].rdata, 32'd1);
    for (int i = 2; i <= 4; i++) begin
      idle();
      chk($sformatf("lat3 beat%0d", i), g_cfg[1].rdata, 32'(i));
    end

    cyc(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 3'd2);
    @(posedge clk); #1;
    dv = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk("lat2 in reset rdata", g_cfg[2].rdata, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("lat2 dropped rdata", g_cfg[2].rdata, 32'h0);
    chk("lat2 dropped rd_err", {31'b0, g_cfg[2].rd_err}, 32'h0);
    chk("lat2 hld after rst", {31'b0, g_cfg[2].hld}, 32'h0);

    for (int i = 0; i < 10; i++) begin
      cyc(hv_dv[9-i], 1'b0, 32'h4, 32'h0, 4'h0, 3'd2);
      chk($sformatf("wait hld step%0d", i), {31'b0, g_cfg[3].hld}, {31'b0, hv_hld[9-i]});
    end
    idle();
    chk("cleared word1", g_cfg[0].rdata, 32'h0);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        @(posedge clk); #1;
        dv = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
      end else begin
        logic [31:0] a;
        int r;
        r = $urandom_range(0, 9);
        if (r < 8)       a = $urandom_range(0, 63);
        else if (r == 8) a = $urandom_range(64, 80);
        else             a = $urandom;
        cyc($urandom_range(0, 9) < 7, 1'($urandom), a, $urandom, 4'($urandom),
            ($urandom_range(0, 9) < 8) ? 3'd2 : 3'($urandom_range(0, 3)));
      end
    end
    idle();
    idle();
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/i3c_axi_sub_mem.md
I3C_AXI_SUB_MEM -- requirements
Module: i3c_axi_sub_mem

Interface
REQ-001 SHALL have parameter AW, default 32, byte-address width.
REQ-002 SHALL have parameter DW, default 32, data width; BC=DW/8 and BW=$clog2(BC) are derived.
REQ-003 SHALL have parameters UW, default 32, and IW, default 1, giving the user and ID widths.
REQ-004 SHALL have parameter DEPTH, default 16, memory depth in DW-bit words, a power of two.
REQ-005 SHALL have parameter C_LAT, default 1, read latency from acceptance to rdata, range 0..3.
REQ-006 SHALL have parameter WAIT_ST, default 0, hold cycles inserted before each accepted beat, range 0..15.
REQ-007 SHALL use one clock and an asynchronous active-low reset: clk input 1 (clock); rst_n input 1 (async reset, active low).
REQ-008 SHALL have the request ports as inputs:
- dv 1, request valid.
- addr AW, byte address.
- write 1, 1=write, 0=read.
- user UW, id IW, last 1: accepted, no effect.
- wdata DW, write data.
- wstrb BC, byte enables.
- size 3, log2 bytes per beat.
REQ-009 SHALL have the response ports as outputs:
- hld 1, stall request.
- rd_err 1, read error, aligned with rdata.
- wr_err 1, write error, aligned with the accepted beat.
- rdata DW, read data.

Function
REQ-010 SHALL treat a beat as accepted in any cycle where dv && !hld.
REQ-011 SHALL keep a wait counter cnt (4 bits): reset value WAIT_ST; hld = (cnt != 0).
- cnt decrements when dv && cnt != 0.
- cnt holds when dv = 0.
- cnt reloads WAIT_ST on acceptance.
REQ-012 SHALL therefore accept, when WAIT_ST = 0, every cycle dv is high, with hld constantly 0.
REQ-013 SHALL select the word index as addr[BW +: $clog2(DEPTH)].
REQ-014 SHALL flag a beat as erroneous if addr[AW-1:BW] >= DEPTH or size > BW.
REQ-015 SHALL, on an accepted write without error, update each byte i where wstrb[i]=1 with wdata[8i+7:8i], visible from the next cycle; bytes with wstrb[i]=0 are unchanged.
REQ-016 SHALL drive wr_err = dv && write && !hld && err combinationally, and SHALL NOT modify memory on an erroneous write.
REQ-017 SHALL, for C_LAT = 0, drive rdata and rd_err combinationally in the acceptance cycle of a read.
REQ-018 SHALL, for C_LAT >= 1, carry {valid, err, data} through C_LAT register stages, so the response appears exactly C_LAT cycles after acceptance.
REQ-019 SHALL drive rdata = 0 and rd_err = 0 in any cycle carrying no read response; an erroneous read returns rdata = 0 and rd_err = 1.
REQ-020 SHALL sample read data at acceptance, so a read accepted the cycle after a write to the same word returns the new data; a write and read cannot be accepted in the same cycle.
REQ-021 SHALL sustain back-to-back accepted reads (one per cycle when WAIT_ST = 0) with no bubbles in the response pipeline.
REQ-022 SHALL ignore write/wdata/wstrb/addr while dv = 0 and SHALL NOT advance cnt.
REQ-023 SHALL tolerate the request fields changing while hld = 1; only the fields present at acceptance matter.

Reset
REQ-024 SHALL, on rst_n low (asynchronous, also mid-operation):
- clear all memory words to 0.
- clear every pipeline stage, so rdata = 0 and rd_err = 0.
- set cnt = WAIT_ST, so hld = (WAIT_ST != 0).
REQ-025 SHALL drop any in-flight read response at reset, never emitting it after reset release.
REQ-026 SHALL keep wr_err combinational and therefore 0 whenever dv = 0 during reset.

Verification
REQ-027 Defaults; write addr 0x8, wdata 0xDEADBEEF, wstrb 0xF; read 0x8 next cycle -> rdata 0xDEADBEEF exactly 1 cycle after acceptance, rd_err 0.
REQ-028 Write 0x11223344 to 0x4, then wdata 0xAABBCCDD with wstrb 0x5 -> readback 0x11BB33DD.
REQ-029 Write to 0x40 (word 16, out of range) -> wr_err 1 in that cycle and memory unchanged; read 0x40 -> rd_err 1 and rdata 0; read with size 3 -> rd_err 1.
REQ-030 WAIT_ST = 3, dv held high -> hld 1 for 3 cycles, acceptance on cycle 4, hld 1 again for the next 3 cycles; dv low for 2 cycles mid-count -> count resumes with no loss.
REQ-031 C_LAT = 3, four back-to-back reads of words 0..3 preloaded with 1..4 -> rdata 1,2,3,4 on consecutive cycles starting 3 cycles after the first acceptance.
REQ-032 C_LAT = 2, rst_n pulsed low one cycle after a read acceptance -> no response appears, all memory reads back 0, and hld = 0 after release with WAIT_ST = 0.
